// File: rtl/mem_axi_master.sv
// mem_axi_master: single-outstanding bridge from the core's simple memory
// request port to an AXI-lite-style SRAM slave port.
//   clk, reset        : clock, asynchronous active-low reset
//   req_*             : core request (valid/ready, wen, addr, wdata, wstrb)
//   resp_*            : single-beat response (valid/ready, rdata, err)
//   ar_*/r_*          : read address / read data channels
//   aw_*/w_*/b*       : write address / write data / write response channels
module mem_axi_master #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_W-1:0]     araddr,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_W-1:0]     rdata,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_t;

  state_t state, state_nxt;
  logic   aw_done, w_done;
  logic   req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic   aw_fin, w_fin;

  // Ready signals are pure state decodes.
  assign req_ready = (state == IDLE);
  assign r_ready   = (state == RDATA);
  assign bready    = (state == WRESP);

  assign req_hs = req_valid && req_ready;
  assign ar_hs  = ar_valid && ar_ready;
  assign r_hs   = r_valid && r_ready;
  assign aw_hs  = aw_valid && aw_ready;
  assign w_hs   = w_valid && w_ready;
  assign b_hs   = bvalid && bready;

  // A write channel is finished if it completed earlier or completes now.
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs) state_nxt = req_wen ? WRITE : RADDR;
      RADDR:   if (ar_hs) state_nxt = RDATA;
      RDATA:   if (r_hs) state_nxt = RESP;
      WRITE:   if (aw_fin && w_fin) state_nxt = WRESP;
      WRESP:   if (b_hs) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered channel outputs, payloads and write-channel done flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ar_valid   <= 1'b0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      araddr     <= '0;
      awaddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            if (req_wen) begin
              awaddr   <= req_addr;
              wdata    <= req_wdata;
              wstrb    <= req_wstrb;
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              aw_done  <= 1'b0;
              w_done   <= 1'b0;
            end else begin
              araddr   <= req_addr;
              ar_valid <= 1'b1;
            end
          end
        end
        RADDR: if (ar_hs) ar_valid <= 1'b0;
        RDATA: begin
          if (r_hs) begin
            resp_rdata <= rdata;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
          end
        end
        WRITE: begin
          if (aw_hs) begin
            aw_valid <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            w_valid <= 1'b0;
            w_done  <= 1'b1;
          end
        end
        WRESP: begin
          if (b_hs) begin
            resp_rdata <= '0;
            resp_err   <= (bresp != 2'b00);
            resp_valid <= 1'b1;
          end
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed self-checking bench for mem_axi_master; the bench acts as core and
// SRAM slave, driving every handshake cycle by cycle.
module tb_mem_axi_master;

  logic        clk, reset;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [63:0] araddr, rdata;
  logic        aw_valid, aw_ready, w_valid, w_ready, bvalid, bready;
  logic [63:0] awaddr, wdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp;

  int passed = 0;
  int total  = 0;
  int ar_cnt = 0;
  int ar_start;

  logic [270:0] all_out;
  assign all_out = {ar_valid, r_ready, aw_valid, w_valid, bready, resp_valid, resp_err,
                    resp_rdata, araddr, awaddr, wdata, wstrb};

  mem_axi_master #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .araddr(araddr),
    .r_valid(r_valid), .r_ready(r_ready), .rdata(rdata),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .awaddr(awaddr),
    .w_valid(w_valid), .w_ready(w_ready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count AR handshakes to prove a single transaction per request.
  always @(posedge clk) if (ar_valid && ar_ready) ar_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passed++;
    total++; if (all_out !== '0) $display("FAIL reset_outputs_zero: got %h want 0", all_out); else passed++;
    reset = 1'b1;
    tick();
    // Enter RADDR, then assert reset between edges.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h40;
    tick();
    req_valid = 1'b0;
    total++; if (ar_valid !== 1'b1) $display("FAIL reset_pre_ar_valid: got %b want 1", ar_valid); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (all_out !== '0) $display("FAIL reset_async_clear: got %h want 0", all_out); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_async_req_ready: got %b want 1", req_ready); else passed++;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait_read();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0010;
    total++; if (req_ready !== 1'b1) $display("FAIL zr_req_ready: got %b want 1", req_ready); else passed++;
    tick(); // cycle 1
    req_valid = 1'b0;
    total++; if (ar_valid !== 1'b1) $display("FAIL zr_ar_valid_c1: got %b want 1", ar_valid); else passed++;
    total++; if (araddr !== 64'h8000_0010) $display("FAIL zr_araddr_c1: got %h want 8000_0010", araddr); else passed++;
    ar_ready = 1'b1;
    tick(); // cycle 2
    ar_ready = 1'b0;
    total++; if ({ar_valid, r_ready} !== 2'b01) $display("FAIL zr_c2_ar_r: got %b want 01", {ar_valid, r_ready}); else passed++;
    r_valid = 1'b1; rdata = 64'hDEAD_BEEF_0123_4567;
    tick(); // cycle 3
    r_valid = 1'b0; rdata = '0;
    total++; if (resp_valid !== 1'b1) $display("FAIL zr_resp_valid_c3: got %b want 1", resp_valid); else passed++;
    total++; if (resp_rdata !== 64'hDEAD_BEEF_0123_4567) $display("FAIL zr_rdata: got %h want DEADBEEF01234567", resp_rdata); else passed++;
    total++; if (resp_err !== 1'b0) $display("FAIL zr_err: got %b want 0", resp_err); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL zr_back_idle: got %b want 01", {resp_valid, req_ready}); else passed++;
  endtask

  task automatic test_stalled_read();
    ar_start = ar_cnt;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0200;
    tick(); // cycle 1
    req_addr = 64'h8000_0300; // second request held valid while busy
    for (int c = 1; c <= 3; c++) begin
      total++; if (ar_valid !== 1'b1 || araddr !== 64'h8000_0200)
        $display("FAIL sr_ar_stable_c%0d: got v=%b a=%h want v=1 a=80000200", c, ar_valid, araddr); else passed++;
      total++; if (req_ready !== 1'b0) $display("FAIL sr_busy_req_ready_c%0d: got %b want 0", c, req_ready); else passed++;
      ar_ready = (c == 3);
      tick();
    end
    ar_ready = 1'b0; // cycle 4
    total++; if ({ar_valid, r_ready} !== 2'b01) $display("FAIL sr_rdata_state: got %b want 01", {ar_valid, r_ready}); else passed++;
    repeat (3) tick(); // r_valid delayed through cycles 4..6
    total++; if (resp_valid !== 1'b0) $display("FAIL sr_no_early_resp: got %b want 0", resp_valid); else passed++;
    r_valid = 1'b1; rdata = 64'hCAFE_F00D_0000_0001;
    tick(); // cycle 8
    r_valid = 1'b0; rdata = '0;
    for (int c = 0; c < 4; c++) begin
      total++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hCAFE_F00D_0000_0001 || resp_err !== 1'b0)
        $display("FAIL sr_resp_hold_%0d: got v=%b d=%h e=%b want v=1 d=CAFEF00D00000001 e=0", c, resp_valid, resp_rdata, resp_err); else passed++;
      total++; if (req_ready !== 1'b0) $display("FAIL sr_resp_busy_%0d: got %b want 0", c, req_ready); else passed++;
      tick();
    end
    resp_ready = 1'b1;
    tick(); // cycle 13
    resp_ready = 1'b0;
    total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL sr_idle_after_resp: got %b want 01", {resp_valid, req_ready}); else passed++;
    total++; if (ar_cnt - ar_start !== 1) $display("FAIL sr_one_txn: got %0d want 1", ar_cnt - ar_start); else passed++;
    tick(); // cycle 14: held request accepted
    req_valid = 1'b0;
    total++; if (ar_valid !== 1'b1 || araddr !== 64'h8000_0300)
      $display("FAIL sr_second_accept: got v=%b a=%h want v=1 a=80000300", ar_valid, araddr); else passed++;
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0; r_valid = 1'b1; rdata = 64'h3;
    tick();
    r_valid = 1'b0; rdata = '0;
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h3)
      $display("FAIL sr_second_resp: got v=%b d=%h want v=1 d=3", resp_valid, resp_rdata); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    total++; if (ar_cnt - ar_start !== 2) $display("FAIL sr_two_txn: got %0d want 2", ar_cnt - ar_start); else passed++;
  endtask

  task automatic test_out_of_order_write();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h100;
    req_wdata = 64'h1122_3344_5566_7788; req_wstrb = 8'h0F;
    tick(); // cycle 1
    req_valid = 1'b0; req_wen = 1'b0;
    total++; if ({aw_valid, w_valid} !== 2'b11) $display("FAIL ow_c1_valids: got %b want 11", {aw_valid, w_valid}); else passed++;
    total++; if (awaddr !== 64'h100 || wdata !== 64'h1122_3344_5566_7788 || wstrb !== 8'h0F)
      $display("FAIL ow_payload: got a=%h d=%h s=%h want a=100 d=1122334455667788 s=0f", awaddr, wdata, wstrb); else passed++;
    w_ready = 1'b1;
    tick(); // cycle 2
    w_ready = 1'b0;
    total++; if ({aw_valid, w_valid, bready} !== 3'b100) $display("FAIL ow_c2: got %b want 100", {aw_valid, w_valid, bready}); else passed++;
    tick(); // cycle 3
    total++; if ({aw_valid, bready} !== 2'b10 || awaddr !== 64'h100)
      $display("FAIL ow_c3: got v/b=%b a=%h want 10 a=100", {aw_valid, bready}, awaddr); else passed++;
    aw_ready = 1'b1;
    tick(); // cycle 4
    aw_ready = 1'b0;
    total++; if ({aw_valid, w_valid, bready} !== 3'b001) $display("FAIL ow_c4: got %b want 001", {aw_valid, w_valid, bready}); else passed++;
    bvalid = 1'b1; bresp = 2'b00;
    tick(); // cycle 5
    bvalid = 1'b0;
    total++; if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== '0)
      $display("FAIL ow_resp: got v/e=%b d=%h want 10 d=0", {resp_valid, resp_err}, resp_rdata); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_error_response();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h180;
    req_wdata = 64'h55; req_wstrb = 8'hFF;
    tick(); // cycle 1
    req_valid = 1'b0; req_wen = 1'b0;
    aw_ready = 1'b1; w_ready = 1'b1;
    tick(); // cycle 2
    aw_ready = 1'b0; w_ready = 1'b0;
    total++; if ({aw_valid, w_valid, bready} !== 3'b001) $display("FAIL er_c2: got %b want 001", {aw_valid, w_valid, bready}); else passed++;
    bvalid = 1'b1; bresp = 2'b10;
    tick(); // cycle 3
    bvalid = 1'b0; bresp = 2'b00;
    total++; if ({resp_valid, resp_err} !== 2'b11 || resp_rdata !== '0)
      $display("FAIL er_resp: got v/e=%b d=%h want 11 d=0", {resp_valid, resp_err}, resp_rdata); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    // Following read clears the error.
    req_valid = 1'b1; req_addr = 64'h188;
    tick();
    req_valid = 1'b0; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0; r_valid = 1'b1; rdata = 64'h77;
    tick();
    r_valid = 1'b0; rdata = '0;
    total++; if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 64'h77)
      $display("FAIL er_read_after: got v/e=%b d=%h want 10 d=77", {resp_valid, resp_err}, resp_rdata); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h200;
    req_wdata = 64'hAA; req_wstrb = 8'h01;
    tick(); // cycle 1
    req_valid = 1'b0; req_wen = 1'b0;
    aw_ready = 1'b1;
    tick(); // cycle 2: aw done, w pending
    aw_ready = 1'b0;
    total++; if ({aw_valid, w_valid} !== 2'b01) $display("FAIL rw_pre: got %b want 01", {aw_valid, w_valid}); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (all_out !== '0 || req_ready !== 1'b1)
      $display("FAIL rw_async_clear: got out=%h rr=%b want 0 rr=1", all_out, req_ready); else passed++;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h300;
    req_wdata = 64'hBB; req_wstrb = 8'h00; // zero-strobe write still issued
    tick(); // cycle 1
    req_valid = 1'b0; req_wen = 1'b0;
    total++; if ({aw_valid, w_valid} !== 2'b11 || awaddr !== 64'h300 || wstrb !== 8'h00)
      $display("FAIL rw_new_write: got v=%b a=%h s=%h want v=11 a=300 s=0", {aw_valid, w_valid}, awaddr, wstrb); else passed++;
    aw_ready = 1'b1; w_ready = 1'b1;
    tick();
    aw_ready = 1'b0; w_ready = 1'b0;
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    total++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL rw_new_resp: got %b want 10", {resp_valid, resp_err}); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; rdata = '0;
    aw_ready = 1'b0; w_ready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    test_reset();
    test_zero_wait_read();
    test_stalled_read();
    test_out_of_order_write();
    test_error_response();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_axi_master.md
# mem_axi_master

Single-outstanding bridge between the core's simple memory-request port (IFU/LSU side) and the five-channel AXI-lite-style slave port of the on-chip SRAM. It sits directly upstream of the SRAM model. Each accepted request becomes exactly one read (AR→R) or one write (AW+W→B) transaction. The result is returned to the core as a single response beat.

## Interface
Parameters:
- ADDR_W, 64, address width of req_addr/araddr/awaddr
- DATA_W, 64, data width; wstrb width is DATA_W/8

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk
- req_valid  in  1  core request valid
- req_ready  out  1  bridge accepts a request
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte strobes
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts the response
- resp_rdata  out  DATA_W  read data; 0 for writes
- resp_err  out  1  1 = write got a nonzero bresp; always 0 for reads
- ar_valid / ar_ready / araddr  out / in / out  1 / 1 / ADDR_W  read address channel
- r_valid / r_ready / rdata  in / out / in  1 / 1 / DATA_W  read data channel
- aw_valid / aw_ready / awaddr  out / in / out  1 / 1 / ADDR_W  write address channel
- w_valid / w_ready / wdata / wstrb  out / in / out / out  1 / 1 / DATA_W / DATA_W/8  write data channel
- bvalid / bready / bresp  in / out / in  1 / 1 / 2  write response channel

## Operation
- FSM states: IDLE, RADDR, RDATA, WRITE, WRESP, RESP.
- IDLE:
  - req_ready=1, all other control outputs 0.
  - On req_valid && req_ready, latch addr, wdata, wstrb and wen.
  - Next state is WRITE if wen=1, else RADDR.
- RADDR:
  - ar_valid=1 and araddr=latched addr, both held stable until ar_ready.
  - Handshake → RDATA.
- RDATA:
  - r_ready=1.
  - On r_valid, capture rdata into resp_rdata, set resp_err=0 → RESP.
- WRITE:
  - aw_valid and w_valid both assert on entry.
  - Each deasserts in the cycle after its own handshake; done flags aw_done and w_done track this.
  - Handshakes may occur in either order or in the same cycle.
  - When both are complete → WRESP.
  - awaddr, wdata and wstrb are held stable throughout.
  - wstrb=0 is still issued as a transaction.
- WRESP:
  - bready=1.
  - On bvalid, set resp_err=(bresp!=2'b00), resp_rdata=0 → RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_ready → IDLE.
- req_ready is 0 in every state except IDLE. Requests presented while busy are not accepted and have no effect.
- Reset:
  - Asynchronous assertion forces IDLE and clears all registered outputs and done flags immediately.
  - An in-flight AXI transaction is abandoned; the SRAM is reset by the same net.
- Outputs ar_valid, aw_valid, w_valid, resp_valid, resp_rdata, resp_err, araddr, awaddr, wdata and wstrb are registered.
- req_ready, r_ready and bready are decoded from state.

## Timing
- Reset values: all valid, ready and bready outputs are 0, except req_ready=1 (IDLE). All address, data, strobe, resp_rdata and resp_err outputs are 0.
- Cycle numbering is relative to the accept edge (cycle 0). In cycle 1, ar_valid or aw_valid/w_valid is high.
- Read, zero-wait slave (ar_ready=1, r_valid in the cycle after AR):
  - AR handshake in cycle 1.
  - r_ready high in cycle 2; R handshake in cycle 2.
  - resp_valid high in cycle 3.
  - Minimum request-to-response latency is 3 cycles.
- Write, zero-wait slave:
  - AW and W handshake in cycle 1; bready high in cycle 2.
  - If bvalid is high in cycle 2, resp_valid is high in cycle 3.
- Each extra slave wait cycle adds exactly one cycle of latency.
- resp_ready backpressure holds RESP indefinitely with no change to any output.
- Next accept is possible in the cycle after the resp_valid && resp_ready handshake.
- A handshake is counted only on a rising edge where valid && ready are both 1.
- r_valid and bvalid are ignored outside RDATA and WRESP respectively.

## Test plan
- Reset:
  - Hold reset=0 for 3 cycles, then release.
  - Required: req_ready=1 and every other output 0. Asserting reset mid-cycle clears outputs without waiting for a clock edge.
- Zero-wait read:
  - Read at addr 0x8000_0010 with ar_ready=1; rdata=0xDEAD_BEEF_0123_4567 returned the cycle after AR.
  - Required: araddr=0x8000_0010 in cycle 1, resp_valid in cycle 3 with that rdata and resp_err=0.
- Stalled read with backpressure:
  - ar_ready low for 2 cycles, r_valid delayed 3 cycles, resp_ready low for 4 cycles.
  - Required: araddr stays stable, resp_valid/resp_rdata stay stable while stalled, exactly one transaction is issued, and a second req_valid held throughout is accepted only after the response handshake.
- Out-of-order write channels:
  - Write addr 0x100, data 0x11223344_55667788, wstrb 0x0F; w_ready high in cycle 1, aw_ready high in cycle 3.
  - Required: w_valid drops in cycle 2, aw_valid drops in cycle 4, bready rises only after both handshakes, and bresp=0 gives resp_err=0.
- Error response:
  - Write with bresp=2'b10.
  - Required: resp_valid with resp_err=1 and resp_rdata=0. A following read completes with resp_err=0.
- Reset mid-write:
  - Assert reset while in WRITE with aw done but w pending.
  - Required: all outputs return to reset values. After release, a new write issues both aw_valid and w_valid.
